tetris_move_sched: RTL and testbench



---
 rtl/tetris_move_sched.sv | 260 ++++++++++++++++++++++++++
 tb/tb_tetris_move_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_move_sched.sv
// -----------------------------------------------------------------------------
// tetris_move_sched
//
// Merges five debounced player buttons and a gravity timer into one stream of
// move requests for the game FSM. Only one move is offered at a time, over a
// valid/ready handshake.
//
// Ports
//   clk         in   clock
//   rst         in   asynchronous active-high reset
//   en          in   game active; low forces IDLE and clears all requests
//   grav_hold   in   freezes the gravity counter (spawn / line clear)
//   btn_right   in   button levels, clk-synchronous and debounced
//   btn_left    in
//   btn_rr      in
//   btn_rl      in
//   btn_down    in
//   move_ready  in   FSM accepts the offered move
//   move_valid  out  a move is offered
//   move_code   out  RIGHT=0 LEFT=1 ROR=2 ROL=3 DOWN=4 NONE=5
//   grav_tick   out  one-cycle pulse when the gravity counter expires
//   dropped     out  one-cycle pulse when a request hits an already-set bit
//
// Build option
//   MOVE_SCHED_DAS_EN  defined: delayed auto-shift repeat on right/left and
//                      periodic soft-drop repeat on down.
//                      undefined: every button is edge-only.
// -----------------------------------------------------------------------------
module tetris_move_sched #(
    parameter int unsigned GRAVITY_TICKS = 25_000_000,
    parameter int unsigned DAS_DELAY     = 4_000_000,
    parameter int unsigned DAS_RATE      = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       grav_hold,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       btn_rr,
    input  logic       btn_rl,
    input  logic       btn_down,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [2:0] move_code,
    output logic       grav_tick,
    output logic       dropped
);

    typedef enum logic [2:0] {
        MV_RIGHT = 3'd0,
        MV_LEFT  = 3'd1,
        MV_ROR   = 3'd2,
        MV_ROL   = 3'd3,
        MV_DOWN  = 3'd4,
        MV_NONE  = 3'd5
    } move_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_OFFER = 2'd2
    } state_t;

    // Pending-bit positions; lower index = higher priority.
    localparam int P_G  = 0;
    localparam int P_R  = 1;
    localparam int P_L  = 2;
    localparam int P_RR = 3;
    localparam int P_RL = 4;
    localparam int P_D  = 5;

    localparam logic [31:0] GRAV_LAST = 32'(GRAVITY_TICKS - 1);
    localparam bit          PARAMS_OK = (GRAVITY_TICKS >= 2) && (DAS_DELAY >= 1) && (DAS_RATE >= 1);

    if (!PARAMS_OK) begin : g_bad_params
        $error("tetris_move_sched: GRAVITY_TICKS must be >= 2, DAS_DELAY and DAS_RATE >= 1");
    end

    state_t      state_q;
    move_t       move_code_q;
    logic        move_valid_q;
    logic        grav_tick_q;
    logic        dropped_q;
    logic [4:0]  btn_prev_q;     // bit order: right, left, rr, rl, down
    logic [5:0]  pend_q;
    logic [5:0]  winner_q;       // one-hot copy of the bit being offered
    logic [31:0] grav_cnt_q;

    logic [4:0]  btn_now;
    logic [4:0]  btn_rise;
    logic [4:0]  das_rep;
    logic        active;
    logic        grav_run;
    logic        grav_expire;
    logic        grant;
    logic        grant_down;
    logic [5:0]  set_req;
    logic [5:0]  clr_mask;
    logic [5:0]  pend_d;
    logic        drop_hit;
    logic [31:0] grav_cnt_d;
    logic [5:0]  arb_pick;
    move_t       arb_code;

    assign btn_now = {btn_down, btn_rl, btn_rr, btn_left, btn_right};

    function automatic move_t pend_code(input int idx);
        case (idx)
            P_R:     return MV_RIGHT;
            P_L:     return MV_LEFT;
            P_RR:    return MV_ROR;
            P_RL:    return MV_ROL;
            default: return MV_DOWN;   // gravity and soft drop
        endcase
    endfunction

`ifdef MOVE_SCHED_DAS_EN
    // Auto-repeat channels: 0 = right, 1 = left, 2 = down. Each keeps a hold
    // counter and the hold count at which it fires next; the next-fire value
    // advances by DAS_RATE after every fire, so no modulo is needed.
    logic [2:0] das_fire;

    for (genvar gi = 0; gi < 3; gi++) begin : g_das
        localparam int          BI    = (gi == 2) ? 4 : gi;
        localparam logic [31:0] FIRST = (gi == 2) ? 32'(DAS_RATE) : 32'(DAS_DELAY);

        logic [31:0] hold_cnt_q;
        logic [31:0] next_fire_q;

        assign das_fire[gi] = active && btn_now[BI] && (hold_cnt_q == next_fire_q);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold_cnt_q  <= '0;
                next_fire_q <= FIRST;
            end else if (!active || !btn_now[BI]) begin
                hold_cnt_q  <= '0;
                next_fire_q <= FIRST;
            end else begin
                hold_cnt_q <= hold_cnt_q + 32'd1;
                if (hold_cnt_q == next_fire_q) begin
                    next_fire_q <= next_fire_q + 32'(DAS_RATE);
                end
            end
        end
    end

    assign das_rep = {das_fire[2], 2'b00, das_fire[1], das_fire[0]};
`else
    assign das_rep = '0;
`endif

    always_comb begin
        active      = en && (state_q != ST_IDLE);
        btn_rise    = btn_now & ~btn_prev_q;
        grav_run    = active && !grav_hold;
        grav_expire = grav_run && (grav_cnt_q == GRAV_LAST);

        set_req = '0;
        if (active) begin
            set_req = {btn_rise | das_rep, grav_expire};
        end

        grant      = active && (state_q == ST_OFFER) && move_ready;
        grant_down = grant && (winner_q[P_G] || winner_q[P_D]);

        // A DOWN grant retires both down sources, since one drop serves both.
        clr_mask = '0;
        if (grant) begin
            clr_mask = winner_q;
            if (grant_down) begin
                clr_mask[P_G] = 1'b1;
                clr_mask[P_D] = 1'b1;
            end
        end

        // Set wins over a same-cycle clear, so the request survives and is
        // served again; that case is not reported as a drop.
        pend_d   = (pend_q & ~clr_mask) | set_req;
        drop_hit = |(set_req & pend_q & ~clr_mask);

        grav_cnt_d = grav_cnt_q;
        if (grant_down) begin
            grav_cnt_d = '0;
        end else if (grav_run) begin
            grav_cnt_d = grav_expire ? 32'd0 : grav_cnt_q + 32'd1;
        end

        // Walk from lowest to highest priority; the last hit is the winner.
        arb_pick = '0;
        arb_code = MV_NONE;
        for (int i = 5; i >= 0; i--) begin
            if (pend_q[i]) begin
                arb_pick = 6'b1 << i;
                arb_code = pend_code(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            move_valid_q <= 1'b0;
            move_code_q  <= MV_NONE;
            grav_tick_q  <= 1'b0;
            dropped_q    <= 1'b0;
            btn_prev_q   <= '0;
            pend_q       <= '0;
            winner_q     <= '0;
            grav_cnt_q   <= '0;
        end else begin
            // Previous levels track the buttons even while idle, so a button
            // already held when the game starts is not taken as a fresh press.
            btn_prev_q  <= btn_now;
            grav_tick_q <= 1'b0;
            dropped_q   <= 1'b0;

            if (!en || state_q == ST_IDLE) begin
                move_valid_q <= 1'b0;
                move_code_q  <= MV_NONE;
                pend_q       <= '0;
                winner_q     <= '0;
                grav_cnt_q   <= '0;
                state_q      <= en ? ST_ARB : ST_IDLE;
            end else begin
                pend_q      <= pend_d;
                grav_cnt_q  <= grav_cnt_d;
                grav_tick_q <= grav_expire;
                dropped_q   <= drop_hit;

                case (state_q)
                    ST_ARB: begin
                        if (|pend_q) begin
                            winner_q     <= arb_pick;
                            move_code_q  <= arb_code;
                            move_valid_q <= 1'b1;
                            state_q      <= ST_OFFER;
                        end
                    end
                    ST_OFFER: begin
                        if (move_ready) begin
                            move_valid_q <= 1'b0;
                            state_q      <= ST_ARB;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign move_valid = move_valid_q;
    assign move_code  = move_code_q;
    assign grav_tick  = grav_tick_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_tetris_move_sched.sv
// -----------------------------------------------------------------------------
// tb_tetris_move_sched
//
// Scenario tasks drive the buttons and push the moves they should cause onto
// a scoreboard queue (code plus the cycle of the handshake). A monitor pops
// one entry for every handshake it sees and compares it. Tasks also check
// pulses and levels inline.
//
// Timing used for expectations (cycle = period after a rising edge):
//   button rise in cycle c -> pending at c+1 -> ARB latches at c+1 ->
//   move_valid (and, with ready high, the handshake) in cycle c+2.
//   Gravity: the counter restarts at 0 on every DOWN grant, so with ready
//   high and no buttons, expiry, offer and grant repeat every
//   GRAVITY_TICKS + 2 cycles.
// -----------------------------------------------------------------------------
module tb_tetris_move_sched;

    localparam int G_TICKS = 8;

    logic       clk;
    logic       rst;
    logic       en;
    logic       grav_hold;
    logic       btn_right;
    logic       btn_left;
    logic       btn_rr;
    logic       btn_rl;
    logic       btn_down;
    logic       move_ready;
    logic       move_valid;
    logic [2:0] move_code;
    logic       grav_tick;
    logic       dropped;

    tetris_move_sched #(
        .GRAVITY_TICKS(G_TICKS),
        .DAS_DELAY    (4),
        .DAS_RATE     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .grav_hold (grav_hold),
        .btn_right (btn_right),
        .btn_left  (btn_left),
        .btn_rr    (btn_rr),
        .btn_rl    (btn_rl),
        .btn_down  (btn_down),
        .move_ready(move_ready),
        .move_valid(move_valid),
        .move_code (move_code),
        .grav_tick (grav_tick),
        .dropped   (dropped)
    );

    typedef struct {
        logic [2:0] code;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   errors   = 0;
    int   checks   = 0;
    int   hs_count = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 2000", cyc);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard monitor: every handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && move_valid && move_ready) begin
            hs_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_move: got code %0d at cycle %0d, expected no move", move_code, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (move_code !== e.code || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL move: got code %0d at cycle %0d, expected code %0d at cycle %0d",
                             move_code, cyc, e.code, e.cyc);
                end else begin
                    $display("move code=%0d cycle=%0d ok", move_code, cyc);
                end
            end
        end
    end

    task automatic push_exp(input logic [2:0] code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic restart(output int r);
        en = 1'b0;
        step(2);
        en = 1'b1;
        r  = cyc;
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; grav_hold = 1'b0; move_ready = 1'b1;
        btn_right = 1'b0; btn_left = 1'b0; btn_rr = 1'b0; btn_rl = 1'b0; btn_down = 1'b0;
        step(3);
        checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", move_valid); end
        checks++; if (move_code !== 3'd5) begin errors++; $display("FAIL reset_code: got %0d expected 5", move_code); end
        checks++; if (grav_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", grav_tick); end
        checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b expected 0", dropped); end
        rst = 1'b0;
        step(3);
        checks++; if (move_valid !== 1'b0 || move_code !== 3'd5) begin
            errors++; $display("FAIL idle_outputs: got valid %b code %0d expected 0 / 5", move_valid, move_code);
        end
        $display("reset checked at cycle %0d", cyc);
    endtask

    task automatic test_gravity();
        int c0;
        int hs0;
        grav_hold = 1'b0;
        en = 1'b1;
        c0 = cyc;
        push_exp(3'd4, c0 + G_TICKS + 2);
        push_exp(3'd4, c0 + 2 * G_TICKS + 4);
        step_to(c0 + G_TICKS + 1);
        checks++; if (grav_tick !== 1'b1 || move_valid !== 1'b0) begin
            errors++; $display("FAIL grav_tick_first: got tick %b valid %b expected 1 / 0", grav_tick, move_valid);
        end
        step_to(c0 + G_TICKS + 2);
        checks++; if (move_valid !== 1'b1 || move_code !== 3'd4) begin
            errors++; $display("FAIL grav_offer: got valid %b code %0d expected 1 / 4", move_valid, move_code);
        end
        checks++; if (grav_tick !== 1'b0) begin
            errors++; $display("FAIL grav_tick_width: got %b expected 0", grav_tick);
        end
        step_to(c0 + 2 * G_TICKS + 3);
        checks++; if (grav_tick !== 1'b1) begin
            errors++; $display("FAIL grav_tick_second: got %b expected 1", grav_tick);
        end
        step_to(c0 + 2 * G_TICKS + 5);
        grav_hold = 1'b1;
        hs0 = hs_count;
        step(30);
        checks++; if (hs_count != hs0 || exp_q.size() != 0) begin
            errors++; $display("FAIL grav_hold: got %0d moves, %0d outstanding expected 0 / 0", hs_count - hs0, exp_q.size());
        end
        $display("gravity checked at cycle %0d", cyc);
    endtask

    task automatic test_same_cycle();
        int r;
        int c;
        grav_hold = 1'b1;
        restart(r);
        c = cyc;
        btn_right = 1'b1;
        btn_rr    = 1'b1;
        push_exp(3'd0, c + 2);
        push_exp(3'd2, c + 4);
        step(1);
        btn_right = 1'b0;
        btn_rr    = 1'b0;
        step_to(c + 7);
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL same_cycle_outstanding: got %0d expected 0", exp_q.size());
        end
        $display("same-cycle priority checked at cycle %0d", cyc);
    endtask

    task automatic test_backpressure();
        int r;
        int c;
        int hs0;
        grav_hold = 1'b1;
        restart(r);
        c = cyc;
        hs0 = hs_count;
        move_ready = 1'b0;
        btn_left   = 1'b1;
        step(1);
        btn_left = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            step_to(c + k);
            checks++; if (move_valid !== 1'b1 || move_code !== 3'd1) begin
                errors++; $display("FAIL stall_hold_%0d: got valid %b code %0d expected 1 / 1", k, move_valid, move_code);
            end
            if (k == 3) btn_left = 1'b1;
        end
        checks++; if (dropped !== 1'b1) begin
            errors++; $display("FAIL dropped_pulse: got %b expected 1", dropped);
        end
        btn_left = 1'b0;
        step_to(c + 5);
        checks++; if (dropped !== 1'b0) begin
            errors++; $display("FAIL dropped_width: got %b expected 0", dropped);
        end
        move_ready = 1'b1;
        push_exp(3'd1, c + 5);
        step_to(c + 10);
        checks++; if (hs_count - hs0 != 1 || exp_q.size() != 0) begin
            errors++; $display("FAIL stall_once: got %0d moves expected 1", hs_count - hs0);
        end
        $display("backpressure checked at cycle %0d", cyc);
    endtask

    task automatic test_grav_down_collision();
        int r;
        grav_hold = 1'b0;
        restart(r);
        step_to(r + G_TICKS);      // cycle in which the counter expires
        btn_down = 1'b1;
        push_exp(3'd4, r + G_TICKS + 2);
        push_exp(3'd4, r + 2 * G_TICKS + 4);
        step(1);
        btn_down = 1'b0;
        step_to(r + 2 * G_TICKS + 3);
        checks++; if (grav_tick !== 1'b1) begin
            errors++; $display("FAIL collision_next_tick: got %b expected 1", grav_tick);
        end
        step_to(r + 2 * G_TICKS + 5);
        grav_hold = 1'b1;
        step(2);
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL collision_outstanding: got %0d expected 0", exp_q.size());
        end
        $display("gravity/down collision checked at cycle %0d", cyc);
    endtask

    task automatic test_das_hold();
        int r;
        int c;
        grav_hold = 1'b1;
        restart(r);
        c = cyc;
        btn_right = 1'b1;
        push_exp(3'd0, c + 2);
`ifdef MOVE_SCHED_DAS_EN
        push_exp(3'd0, c + 6);
        push_exp(3'd0, c + 8);
        push_exp(3'd0, c + 10);
        push_exp(3'd0, c + 12);
`endif
        step_to(c + 12);
        btn_right = 1'b0;
        step_to(c + 16);
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL das_outstanding: got %0d expected 0", exp_q.size());
        end
        $display("held right checked at cycle %0d", cyc);
    endtask

    task automatic test_abort();
        int r;
        int c;
        int hs0;
        grav_hold = 1'b1;
        restart(r);
        c = cyc;
        hs0 = hs_count;
        move_ready = 1'b0;
        btn_rl = 1'b1;
        step(1);
        btn_rl = 1'b0;
        btn_rr = 1'b1;
        step(1);
        btn_rr = 1'b0;
        checks++; if (move_valid !== 1'b1 || move_code !== 3'd3) begin
            errors++; $display("FAIL abort_offer: got valid %b code %0d expected 1 / 3", move_valid, move_code);
        end
        en = 1'b0;
        step(1);
        checks++; if (move_valid !== 1'b0 || move_code !== 3'd5) begin
            errors++; $display("FAIL abort_outputs: got valid %b code %0d expected 0 / 5", move_valid, move_code);
        end
        checks++; if (dut.state_q !== 2'd0) begin
            errors++; $display("FAIL abort_state: got %0d expected 0 (IDLE)", dut.state_q);
        end
        checks++; if (dut.pend_q !== 6'd0) begin
            errors++; $display("FAIL abort_pending: got %b expected 000000", dut.pend_q);
        end
        en = 1'b1;
        move_ready = 1'b1;
        step(10);
        checks++; if (hs_count != hs0 || move_valid !== 1'b0) begin
            errors++; $display("FAIL abort_stale: got %0d moves valid %b expected 0 / 0", hs_count - hs0, move_valid);
        end
        $display("abort checked at cycle %0d (start %0d)", cyc, c);
    endtask

    initial begin
        test_reset();
        test_gravity();
        test_same_cycle();
        test_backpressure();
        test_grav_down_collision();
        test_das_hold();
        test_abort();
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL final_outstanding: got %0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
